// File: rtl/fft_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_pkg : shared widths and twiddle types for the FFT datapath      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package fft_pkg;

  localparam int DW      = 16;
  localparam int PW      = 32;
  localparam int TW_W    = 16;
  localparam int TW_FRAC = 12;
  localparam int TW_N    = 32;

  typedef logic signed [TW_W-1:0] tw_t;

  typedef struct packed {
    tw_t re;
    tw_t im;
  } tw_pair_t;

  typedef tw_pair_t [TW_N-1:0] tw_table_t;

endpackage
`default_nettype wire

// File: rtl/twiddle_rom_64.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | twiddle_rom_64 : combinational W64^k lookup, k = 0..31, Q4.12       |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module twiddle_rom_64
  import fft_pkg::*;
(
  input  logic [4:0] i_idx,
  output tw_t        o_wr,
  output tw_t        o_wi
);

  // Wr = round(4096*cos(2*pi*k/64)), Wi = round(-4096*sin(2*pi*k/64))
  always_comb begin
    o_wr = '0;
    o_wi = '0;
    case (i_idx)
      5'd0:  begin o_wr =  16'sd4096; o_wi =  16'sd0;    end
      5'd1:  begin o_wr =  16'sd4076; o_wi = -16'sd401;  end
      5'd2:  begin o_wr =  16'sd4017; o_wi = -16'sd799;  end
      5'd3:  begin o_wr =  16'sd3920; o_wi = -16'sd1189; end
      5'd4:  begin o_wr =  16'sd3784; o_wi = -16'sd1567; end
      5'd5:  begin o_wr =  16'sd3612; o_wi = -16'sd1931; end
      5'd6:  begin o_wr =  16'sd3406; o_wi = -16'sd2276; end
      5'd7:  begin o_wr =  16'sd3166; o_wi = -16'sd2598; end
      5'd8:  begin o_wr =  16'sd2896; o_wi = -16'sd2896; end
      5'd9:  begin o_wr =  16'sd2598; o_wi = -16'sd3166; end
      5'd10: begin o_wr =  16'sd2276; o_wi = -16'sd3406; end
      5'd11: begin o_wr =  16'sd1931; o_wi = -16'sd3612; end
      5'd12: begin o_wr =  16'sd1567; o_wi = -16'sd3784; end
      5'd13: begin o_wr =  16'sd1189; o_wi = -16'sd3920; end
      5'd14: begin o_wr =  16'sd799;  o_wi = -16'sd4017; end
      5'd15: begin o_wr =  16'sd401;  o_wi = -16'sd4076; end
      5'd16: begin o_wr =  16'sd0;    o_wi = -16'sd4096; end
      5'd17: begin o_wr = -16'sd401;  o_wi = -16'sd4076; end
      5'd18: begin o_wr = -16'sd799;  o_wi = -16'sd4017; end
      5'd19: begin o_wr = -16'sd1189; o_wi = -16'sd3920; end
      5'd20: begin o_wr = -16'sd1567; o_wi = -16'sd3784; end
      5'd21: begin o_wr = -16'sd1931; o_wi = -16'sd3612; end
      5'd22: begin o_wr = -16'sd2276; o_wi = -16'sd3406; end
      5'd23: begin o_wr = -16'sd2598; o_wi = -16'sd3166; end
      5'd24: begin o_wr = -16'sd2896; o_wi = -16'sd2896; end
      5'd25: begin o_wr = -16'sd3166; o_wi = -16'sd2598; end
      5'd26: begin o_wr = -16'sd3406; o_wi = -16'sd2276; end
      5'd27: begin o_wr = -16'sd3612; o_wi = -16'sd1931; end
      5'd28: begin o_wr = -16'sd3784; o_wi = -16'sd1567; end
      5'd29: begin o_wr = -16'sd3920; o_wi = -16'sd1189; end
      5'd30: begin o_wr = -16'sd4017; o_wi = -16'sd799;  end
      5'd31: begin o_wr = -16'sd4076; o_wi = -16'sd401;  end
      default: begin o_wr = '0; o_wi = '0; end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cmul_tw_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cmul_tw_pipe : 3-stage complex multiply by W64^k with global stall  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module cmul_tw_pipe
  import fft_pkg::*;
#(
  parameter int DW = fft_pkg::DW,
  parameter int PW = fft_pkg::PW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic signed [DW-1:0] i_data_in_re,
  input  logic signed [DW-1:0] i_data_in_im,
  input  logic [4:0]           i_tw_idx,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic signed [PW-1:0] o_data_out_re,
  output logic signed [PW-1:0] o_data_out_im
);

  logic                 w_en;
  tw_t                  w_wr;
  tw_t                  w_wi;

  logic                 r_v1;
  logic signed [DW-1:0] r_s1_are;
  logic signed [DW-1:0] r_s1_aim;
  tw_t                  r_s1_wr;
  tw_t                  r_s1_wi;

  logic                 r_v2;
  logic signed [PW-1:0] r_pp_rr;
  logic signed [PW-1:0] r_pp_ii;
  logic signed [PW-1:0] r_pp_ri;
  logic signed [PW-1:0] r_pp_ir;

  logic                 r_v3;
  logic signed [PW-1:0] r_out_re;
  logic signed [PW-1:0] r_out_im;

  logic signed [PW-1:0] w_are_x;
  logic signed [PW-1:0] w_aim_x;
  logic signed [PW-1:0] w_wr_x;
  logic signed [PW-1:0] w_wi_x;

  // Single enable for the whole pipe: any stall at the output freezes every stage.
  assign w_en       = !r_v3 || i_out_ready;
  assign o_in_ready = w_en;

  twiddle_rom_64 u_rom (
    .i_idx (i_tw_idx),
    .o_wr  (w_wr),
    .o_wi  (w_wi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_s1_are <= '0;
      r_s1_aim <= '0;
      r_s1_wr  <= '0;
      r_s1_wi  <= '0;
    end else if (w_en) begin
      r_v1     <= i_in_valid;
      r_s1_are <= i_data_in_re;
      r_s1_aim <= i_data_in_im;
      r_s1_wr  <= w_wr;
      r_s1_wi  <= w_wi;
    end
  end

  // Operands are sign-extended to PW so the products are full precision.
  assign w_are_x = PW'(r_s1_are);
  assign w_aim_x = PW'(r_s1_aim);
  assign w_wr_x  = PW'(r_s1_wr);
  assign w_wi_x  = PW'(r_s1_wi);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2    <= 1'b0;
      r_pp_rr <= '0;
      r_pp_ii <= '0;
      r_pp_ri <= '0;
      r_pp_ir <= '0;
    end else if (w_en) begin
      r_v2    <= r_v1;
      r_pp_rr <= w_are_x * w_wr_x;
      r_pp_ii <= w_aim_x * w_wi_x;
      r_pp_ri <= w_are_x * w_wi_x;
      r_pp_ir <= w_aim_x * w_wr_x;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v3     <= 1'b0;
      r_out_re <= '0;
      r_out_im <= '0;
    end else if (w_en) begin
      r_v3     <= r_v2;
      r_out_re <= r_pp_rr - r_pp_ii;
      r_out_im <= r_pp_ri + r_pp_ir;
    end
  end

  assign o_out_valid   = r_v3;
  assign o_data_out_re = r_out_re;
  assign o_data_out_im = r_out_im;

endmodule
`default_nettype wire

// File: tb/tb_cmul_tw_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cmul_tw_pipe : scoreboard bench for cmul_tw_pipe                 |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_cmul_tw_pipe;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               i_in_valid = 1'b0;
  logic               o_in_ready;
  logic signed [15:0] i_data_in_re = '0;
  logic signed [15:0] i_data_in_im = '0;
  logic [4:0]         i_tw_idx = '0;
  logic               o_out_valid;
  logic               i_out_ready = 1'b1;
  logic signed [31:0] o_data_out_re;
  logic signed [31:0] o_data_out_im;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [31:0] re;
    logic signed [31:0] im;
    int                 acc_cyc;
    int                 acc_stall;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          stall_cnt = 0;
  bit          front_seen = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_re = '0;
  logic [31:0] prev_im = '0;

  cmul_tw_pipe #(.DW(16), .PW(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_in_valid    (i_in_valid),
    .o_in_ready    (o_in_ready),
    .i_data_in_re  (i_data_in_re),
    .i_data_in_im  (i_data_in_im),
    .i_tw_idx      (i_tw_idx),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_data_out_re (o_data_out_re),
    .o_data_out_im (o_data_out_im)
  );

  always #5 clk = ~clk;

  function automatic int tw_re(input int k);
    real a;
    a = 2.0 * 3.14159265358979 * k / 64.0;
    return $rtoi($floor(4096.0 * $cos(a) + 0.5));
  endfunction

  function automatic int tw_im(input int k);
    real a;
    a = 2.0 * 3.14159265358979 * k / 64.0;
    return $rtoi($floor(-4096.0 * $sin(a) + 0.5));
  endfunction

  function automatic logic signed [31:0] prod_re(input int ar, input int ai, input int k);
    return ar * tw_re(k) - ai * tw_im(k);
  endfunction

  function automatic logic signed [31:0] prod_im(input int ar, input int ai, input int k);
    return ar * tw_im(k) + ai * tw_re(k);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted sample must come out once, in order, with the
  // product of its twiddle and after 3 cycles plus any stall cycles in between.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      front_seen = 1'b0;
      prev_stall = 1'b0;
      check("rst_out_valid", {31'b0, o_out_valid}, 32'd0);
      check("rst_out_re", o_data_out_re, 32'd0);
      check("rst_out_im", o_data_out_im, 32'd0);
    end else begin
      check("in_ready_rule", {31'b0, o_in_ready}, {31'b0, (!o_out_valid || i_out_ready)});
      if (prev_stall) begin
        check("hold_valid", {31'b0, o_out_valid}, 32'd1);
        check("hold_re", o_data_out_re, prev_re);
        check("hold_im", o_data_out_im, prev_im);
      end
      if (o_out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out", {31'b0, o_out_valid}, 32'd0);
        end else begin
          if (!front_seen) begin
            check("latency", cyc - q[0].acc_cyc, 3 + stall_cnt - q[0].acc_stall);
            front_seen = 1'b1;
          end
          check("out_re", o_data_out_re, q[0].re);
          check("out_im", o_data_out_im, q[0].im);
          if (i_out_ready) begin
            void'(q.pop_front());
            front_seen = 1'b0;
          end
        end
      end
      if (!o_in_ready) stall_cnt++;
      if (i_in_valid && o_in_ready)
        q.push_back(exp_t'{prod_re(int'(i_data_in_re), int'(i_data_in_im), int'(i_tw_idx)),
                           prod_im(int'(i_data_in_re), int'(i_data_in_im), int'(i_tw_idx)),
                           cyc, stall_cnt});
      prev_stall = o_out_valid && !i_out_ready;
      prev_re    = o_data_out_re;
      prev_im    = o_data_out_im;
    end
  end

  // Starts and ends just after a rising edge; holds the sample until accepted.
  task automatic send(input int ar, input int ai, input int k, output int waits);
    waits        = 0;
    i_in_valid   = 1'b1;
    i_data_in_re = 16'(ar);
    i_data_in_im = 16'(ai);
    i_tw_idx     = 5'(k);
    @(negedge clk);
    while (!o_in_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!o_in_ready) check("send_timeout", {31'b0, o_in_ready}, 32'd1);
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
  endtask

  task automatic send_expect(input int ar, input int ai, input int k,
                             input logic [31:0] exp_re, input logic [31:0] exp_im);
    int w;
    send(ar, ai, k, w);
    @(negedge clk);
    check("lit_early1", {31'b0, o_out_valid}, 32'd0);
    @(negedge clk);
    check("lit_early2", {31'b0, o_out_valid}, 32'd0);
    @(negedge clk);
    check("lit_valid", {31'b0, o_out_valid}, 32'd1);
    check("lit_re", o_data_out_re, exp_re);
    check("lit_im", o_data_out_im, exp_im);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    #2;
    check("init_valid", {31'b0, o_out_valid}, 32'd0);
    check("init_re", o_data_out_re, 32'd0);
    check("init_im", o_data_out_im, 32'd0);
    check("init_in_ready", {31'b0, o_in_ready}, 32'd1);
    // A valid sample offered during reset must not be captured.
    i_in_valid   = 1'b1;
    i_data_in_re = 16'sd1234;
    i_data_in_im = 16'sd77;
    i_tw_idx     = 5'd3;
    repeat (3) @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    rst        = 1'b0;
    idle(1);

    send_expect(1000, 0, 0, 32'h003E8000, 32'h00000000);
    send_expect(1000, 0, 16, 32'h00000000, 32'hFFC18000);
    send_expect(4096, 4096, 8, 32'd23724032, 32'd0);
    send_expect(-32768, -32768, 24, 32'd0, 32'h0B500000);

    for (int k = 0; k < 32; k++) begin
      send(4096, 0, k, w);
      check("stream_in_ready", w, 32'd0);
    end
    idle(6);

    for (int i = 0; i < 8; i++) begin
      send(i * 1000 - 3000, 500 * i - 1700, i * 3 + 1, w);
      idle(i % 3);
    end
    idle(6);

    fork
      begin
        for (int i = 0; i < 12; i++) send(-2500 + 417 * i, 3000 - 311 * i, 31 - 2 * i, w);
      end
      begin
        idle(6);
        i_out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check("stall_in_ready", {31'b0, o_in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        i_out_ready = 1'b1;
      end
    join
    idle(8);

    for (int i = 0; i < 3; i++) send(300 + i, -200 - i, 5 + i, w);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'b0, o_out_valid}, 32'd0);
    check("mid_rst_re", o_data_out_re, 32'd0);
    check("mid_rst_im", o_data_out_im, 32'd0);
    i_in_valid   = 1'b1;
    i_data_in_re = 16'sd999;
    i_data_in_im = 16'sd999;
    i_tw_idx     = 5'd9;
    @(posedge clk);
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    rst        = 1'b0;
    idle(1);
    send_expect(2000, -1000, 4, 32'sd6001000, -32'sd6918000);

    idle(6);
    check("queue_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cmul_tw_pipe.md
CMUL_TW_PIPE -- requirements
Module: cmul_tw_pipe

Interface
REQ-001 SHALL have parameter DW, default 16: width of each signed data component in.
REQ-002 SHALL have parameter PW, default 32: width of each signed product component out, equal to 2*DW.
REQ-003 SHALL have a single clock and an asynchronous, active-high reset.
REQ-004 Clk  in  1  rising-edge clock for all state.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 In_valid  in  1  input sample valid.
REQ-007 In_ready  out  1  block accepts a sample this cycle.
REQ-008 Data_in_re  in  DW  signed real part of A.
REQ-009 Data_in_im  in  DW  signed imaginary part of A.
REQ-010 Tw_idx  in  5  twiddle index k, selecting W = W64^k.
REQ-011 Out_valid  out  1  product valid.
REQ-012 Out_ready  in  1  downstream (32b-to-16b bit adjuster pair) accepts.
REQ-013 Data_out_re  out  PW  signed real product, Q.12 scaling.
REQ-014 Data_out_im  out  PW  signed imaginary product, Q.12 scaling.

Function
REQ-015 SHALL compute P = A*W: Pr = Ar*Wr - Ai*Wi; Pi = Ar*Wi + Ai*Wr.
REQ-016 W64^k SHALL be (cos(2*pi*k/64), -sin(2*pi*k/64)), each rounded to nearest in signed Q4.12 (1.0 = 4096); e.g. k=0 (4096,0), k=8 (2896,-2896), k=16 (0,-4096), k=24 (-2896,-2896).
REQ-017 Products SHALL be full-precision 32-bit signed; sums SHALL be two's complement modulo 2^PW, no saturation or rounding.
REQ-018 Pipeline SHALL have three stages: S1 registers A plus the ROM twiddle, S2 registers the four partial products, S3 registers the add/sub results.
REQ-019 Each stage SHALL hold one valid bit; Out_valid SHALL equal the S3 valid bit.
REQ-020 Global advance enable SHALL be en = !Out_valid || Out_ready; In_ready SHALL equal en.
REQ-021 On a cycle with en=1, all stages SHALL shift, and S1 valid SHALL load In_valid.
REQ-022 On a cycle with en=0, all stage registers and valid bits SHALL hold.
REQ-023 Latency SHALL be 3 cycles from an accepted input (In_valid && In_ready) to Out_valid, with no stall.
REQ-024 Throughput SHALL be one sample per cycle while Out_ready=1.
REQ-025 Data_out_re and Data_out_im SHALL stay stable while Out_valid=1 and Out_ready=0.
REQ-026 Bubbles (In_valid=0 while en=1) SHALL propagate as invalid stages and SHALL NOT be collapsed.
REQ-027 Sample order SHALL be preserved; no sample SHALL be dropped or duplicated.

Reset
REQ-028 Reset assertion SHALL asynchronously clear all valid bits and all data registers to 0, so Out_valid=0, Data_out_re=0 and Data_out_im=0.
REQ-029 With Out_valid=0 during reset, In_ready SHALL read 1, but no sample SHALL be captured while Reset=1.
REQ-030 Reset mid-stream SHALL discard all in-flight samples; the first sample accepted after deassertion SHALL emerge 3 cycles later.

Structure
REQ-031 Package fft_pkg SHALL hold DW, PW, TW_FRAC=12 and the twiddle table type (32 entries x 2 x 16b).
REQ-032 Sub-module twiddle_rom_64 SHALL be a combinational 32-entry lookup from Tw_idx to (Wr,Wi), with its output registered in S1.
REQ-033 Multipliers and adders SHALL be inferred; no vendor primitives.

Verification
REQ-034 A=(1000,0), k=0 -> 3 cycles later Pr=0x003E8000, Pi=0.
REQ-035 A=(1000,0), k=16 -> Pr=0, Pi=0xFFC18000 (-4096000).
REQ-036 A=(4096,4096), k=8 -> Pr=23724032, Pi=0; A=(-32768,-32768), k=24 -> Pr=0, Pi=0x0B500000.
REQ-037 Stream k=0..31 back-to-back with A=(4096,0), Out_ready=1 -> 32 consecutive outputs equal to the ROM Wr,Wi times 4096; In_ready constant 1.
REQ-038 Out_ready held 0 for 5 cycles during a stream -> outputs held stable, In_ready=0, no loss or duplication; order intact after release.
REQ-039 Reset pulse asserted with 3 samples in flight -> Out_valid drops immediately and outputs are 0; the next accepted sample appears exactly 3 cycles after acceptance.
